// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package if_pkg;

  localparam int unsigned XLEN     = 32;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;
  localparam logic [31:0] PC_STEP  = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Redirect, instruction-memory and decode-side signals of the fetch sequencer.
interface if_fetch_ctrl_if;

  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  // Pulses when an rvalid arrives with nothing outstanding.
  logic        proto_err_o;

  modport master (
    input  redirect_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, id_ready_i,
    output imem_req_o, imem_addr_o, id_valid_o, id_pc_o, id_inst_o, proto_err_o
  );

  modport slave (
    output redirect_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, id_ready_i,
    input  imem_req_o, imem_addr_o, id_valid_o, id_pc_o, id_inst_o, proto_err_o
  );

endinterface

// File: rtl/if_fetch_buf.sv
// Small synchronous FIFO of fetch entries with flush and occupancy count.
module if_fetch_buf
  import if_pkg::*;
#(
  parameter int unsigned DEPTH = 3,
  localparam int unsigned CW = $clog2(DEPTH + 1),
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop && (cnt_q != '0);
  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign do_push = push && ((cnt_q != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= wdata;
        wr_q        <= ptr_inc(wr_q);
      end
      if (do_pop) rd_q <= ptr_inc(rd_q);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  assign head  = mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, issues imem requests, drops stale responses after a
// redirect and queues returned instructions for decode.
module if_fetch_ctrl
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 3
) (
  input logic            clk,
  input logic            rst,
  if_fetch_ctrl_if.master bus
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] buf_cnt, aq_cnt;
  logic [CW:0]   occ;
  logic          fire, rv, aq_pop, keep, id_pop;
  fetch_entry_t  buf_head, aq_head, buf_wdata, aq_wdata;

  assign occ  = {1'b0, buf_cnt} + {1'b0, inflight_q};
  // Issue depends only on registered occupancy, never on id_ready_i.
  assign bus.imem_req_o  = !rst && !bus.redirect_i && (occ < (CW + 1)'(DEPTH));
  assign bus.imem_addr_o = pc_q;

  assign fire   = bus.imem_req_o && bus.imem_gnt_i;
  assign rv     = bus.imem_rvalid_i && (inflight_q != '0);
  assign aq_pop = rv && (drop_q == '0) && (aq_cnt != '0);
  assign keep   = aq_pop && !bus.redirect_i;
  assign id_pop = bus.id_valid_o && bus.id_ready_i;

  assign bus.proto_err_o = !rst && bus.imem_rvalid_i && (inflight_q == '0);

  always_comb begin
    pc_d       = pc_q;
    inflight_d = inflight_q + CW'(fire) - CW'(rv);
    drop_d     = drop_q;
    if (rv && (drop_q != '0)) drop_d = drop_q - 1'b1;
    if (fire) pc_d = pc_q + PC_STEP;
    if (bus.redirect_i) begin
      pc_d   = {bus.redirect_pc_i[31:2], 2'b00};
      // Everything still outstanding after this cycle is now stale.
      drop_d = inflight_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  assign aq_wdata  = '{pc: pc_q, inst: INST_NOP};
  assign buf_wdata = '{pc: aq_head.pc, inst: bus.imem_rdata_i};

  if_fetch_buf #(.DEPTH(DEPTH)) u_addr_q (
    .clk   (clk),
    .rst   (rst),
    .push  (fire),
    .pop   (aq_pop),
    .flush (bus.redirect_i),
    .wdata (aq_wdata),
    .head  (aq_head),
    .count (aq_cnt)
  );

  if_fetch_buf #(.DEPTH(DEPTH)) u_fetch_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (keep),
    .pop   (id_pop),
    .flush (bus.redirect_i),
    .wdata (buf_wdata),
    .head  (buf_head),
    .count (buf_cnt)
  );

  assign bus.id_valid_o = (buf_cnt != '0);
  assign bus.id_pc_o    = buf_head.pc;
  assign bus.id_inst_o  = buf_head.inst;

  logic unused_bits;
  assign unused_bits = ^{aq_head.inst, bus.redirect_pc_i[1:0]};

`ifdef IF_FETCH_STRICT_PROTO
  assert property (@(posedge clk) disable iff (rst) !bus.proto_err_o)
    else $error("rvalid with no request outstanding");
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl with a queue-based scoreboard on the decode side.
module tb_if_fetch_ctrl;
  import if_pkg::*;

  typedef struct {
    logic [31:0] a;
    int          due;
  } pend_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_nxt = 1'b1;
  always #5 clk = ~clk;

  if_fetch_ctrl_if bus ();

  if_fetch_ctrl #(.RESET_PC(32'h0000_0000), .DEPTH(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int t_cmp = 0;
  int cyc = -1;
  int mem_lat = 1;
  bit gnt_en = 1'b0;
  fetch_entry_t sb[$];
  pend_t pend[$];

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle: drive memory response and controls at negedge, record grants at +1.
  task automatic step(input bit rdy, input bit redir, input logic [31:0] tgt);
    @(negedge clk);
    rst = rst_nxt;
    cyc++;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      bus.imem_rvalid_i = 1'b1;
      bus.imem_rdata_i  = mdata(pend[0].a);
      void'(pend.pop_front());
    end else begin
      bus.imem_rvalid_i = 1'b0;
      bus.imem_rdata_i  = 32'h0;
    end
    bus.id_ready_i    = rdy;
    bus.redirect_i    = redir;
    bus.redirect_pc_i = tgt;
    bus.imem_gnt_i    = gnt_en;
    #1;
    if (bus.imem_req_o && bus.imem_gnt_i) pend.push_back('{a: bus.imem_addr_o, due: cyc + mem_lat});
  endtask

  task automatic clear_inputs();
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'h0;
    bus.imem_gnt_i    = 1'b0;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = 32'h0;
    bus.id_ready_i    = 1'b0;
  endtask

  task automatic reset_dut();
    rst     = 1'b1;
    rst_nxt = 1'b1;
    clear_inputs();
    pend.delete();
    sb.delete();
    t_cmp   = 0;
    mem_lat = 1;
    gnt_en  = 1'b0;
    repeat (2) @(negedge clk);
    rst_nxt = 1'b0;
    cyc     = -1;
  endtask

  task automatic expect_stream(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) sb.push_back('{pc: base + 32'(4 * i), inst: mdata(base + 32'(4 * i))});
  endtask

  task automatic end_test(input string name, input int min_pops);
    n_cmp++;
    if (t_cmp < min_pops) begin
      n_bad++;
      $display("FAIL %s_throughput: got %0d pops expected at least %0d", name, t_cmp, min_pops);
    end
    rst = 1'b1;
    sb.delete();
  endtask

  // Monitor: compare every decode handshake against the scoreboard head.
  initial begin
    fetch_entry_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst !== 1'b1 && bus.id_valid_o === 1'b1 && bus.id_ready_i === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_pop: got pc %h expected no entry", bus.id_pc_o);
        end else begin
          e = sb.pop_front();
          check("id_pc", bus.id_pc_o, e.pc);
          check("id_inst", bus.id_inst_o, e.inst);
          t_cmp++;
        end
      end
    end
  end

  initial begin
    clear_inputs();
    #1;
    check("rst_req", 32'(bus.imem_req_o), 32'h0);
    check("rst_valid", 32'(bus.id_valid_o), 32'h0);
    check("rst_pc", bus.id_pc_o, 32'h0);
    check("rst_inst", bus.id_inst_o, 32'h0);
    check("rst_addr", bus.imem_addr_o, 32'h0);

    // 1. Streaming at one instruction per cycle.
    reset_dut();
    gnt_en = 1'b1;
    expect_stream(32'h0, 40);
    for (int s = 0; s < 16; s++) begin
      step(1'b1, 1'b0, 32'h0);
      if (s == 0) begin
        check("t1_first_req", 32'(bus.imem_req_o), 32'h1);
        check("t1_first_addr", bus.imem_addr_o, 32'h0);
      end
      if (s == 1) check("t1_latency", 32'(bus.id_valid_o), 32'h0);
      if (s >= 2) check("t1_gap", 32'(bus.id_valid_o), 32'h1);
    end
    end_test("t1", 12);

    // 2. Backpressure fills the buffer, then drains without loss.
    reset_dut();
    gnt_en = 1'b1;
    expect_stream(32'h0, 40);
    for (int s = 0; s < 8; s++) begin
      step(1'b0, 1'b0, 32'h0);
      if (s >= 3) check("t2_req_low", 32'(bus.imem_req_o), 32'h0);
      if (s >= 2) check("t2_hold_pc", bus.id_pc_o, 32'h0);
    end
    check("t2_hold_valid", 32'(bus.id_valid_o), 32'h1);
    check("t2_hold_inst", bus.id_inst_o, mdata(32'h0));
    for (int r = 0; r < 10; r++) begin
      step(1'b1, 1'b0, 32'h0);
      if (r == 0) check("t2_no_ready_path", 32'(bus.imem_req_o), 32'h0);
      if (r == 1) begin
        check("t2_resume_req", 32'(bus.imem_req_o), 32'h1);
        check("t2_resume_addr", bus.imem_addr_o, 32'hC);
      end
    end
    end_test("t2", 8);

    // 3. Grant stall holds the request and address.
    reset_dut();
    gnt_en = 1'b0;
    expect_stream(32'h0, 40);
    for (int s = 0; s < 5; s++) begin
      step(1'b1, 1'b0, 32'h0);
      check("t3_stall_req", 32'(bus.imem_req_o), 32'h1);
      check("t3_stall_addr", bus.imem_addr_o, 32'h0);
    end
    gnt_en = 1'b1;
    for (int s = 5; s < 13; s++) begin
      step(1'b1, 1'b0, 32'h0);
      if (s == 6) check("t3_advance", bus.imem_addr_o, 32'h4);
    end
    end_test("t3", 4);

    // 4. Redirect with two requests in flight to a misaligned target.
    reset_dut();
    mem_lat = 3;
    gnt_en  = 1'b1;
    expect_stream(32'h100, 20);
    for (int s = 0; s < 15; s++) begin
      step(1'b1, (s == 2), (s == 2) ? 32'h103 : 32'h0);
      if (s == 2) check("t4_req_redirect", 32'(bus.imem_req_o), 32'h0);
      if (s == 3) begin
        check("t4_new_req", 32'(bus.imem_req_o), 32'h1);
        check("t4_new_addr", bus.imem_addr_o, 32'h100);
      end
      if (s >= 3 && s <= 6) check("t4_stale_hidden", 32'(bus.id_valid_o), 32'h0);
      if (s == 7) check("t4_first_new", 32'(bus.id_valid_o), 32'h1);
    end
    end_test("t4", 3);

    // 5. Redirect coinciding with a pop and an rvalid.
    reset_dut();
    gnt_en = 1'b1;
    expect_stream(32'h0, 4);
    expect_stream(32'h200, 20);
    for (int s = 0; s < 13; s++) begin
      step(1'b1, (s == 5), (s == 5) ? 32'h200 : 32'h0);
      if (s == 5) check("t5_rvalid_present", 32'(bus.imem_rvalid_i), 32'h1);
      if (s == 6 || s == 7) check("t5_flushed", 32'(bus.id_valid_o), 32'h0);
      if (s == 6) check("t5_new_addr", bus.imem_addr_o, 32'h200);
    end
    end_test("t5", 8);

    // 6. Asynchronous reset mid-burst, with a stale response arriving afterwards.
    reset_dut();
    gnt_en = 1'b1;
    expect_stream(32'h0, 40);
    for (int s = 0; s < 5; s++) step(1'b1, 1'b0, 32'h0);
    #2;
    rst     = 1'b1;
    rst_nxt = 1'b0;
    #1;
    check("t6_req", 32'(bus.imem_req_o), 32'h0);
    check("t6_valid", 32'(bus.id_valid_o), 32'h0);
    check("t6_pc", bus.id_pc_o, 32'h0);
    check("t6_inst", bus.id_inst_o, 32'h0);
    check("t6_addr", bus.imem_addr_o, 32'h0);
    sb.delete();
    t_cmp = 0;
    expect_stream(32'h0, 40);
    for (int s = 5; s < 13; s++) begin
      step(1'b1, 1'b0, 32'h0);
      if (s == 5) begin
        check("t6_stale_rvalid", 32'(bus.imem_rvalid_i), 32'h1);
        check("t6_flag", 32'(bus.proto_err_o), 32'h1);
        check("t6_restart_addr", bus.imem_addr_o, 32'h0);
        check("t6_restart_req", 32'(bus.imem_req_o), 32'h1);
      end
      if (s == 6) check("t6_flag_clear", 32'(bus.proto_err_o), 32'h0);
    end
    end_test("t6", 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
